// File: rtl/regfile_port_sequencer_if.sv
// Bundle between the regfile port sequencer, its requester/consumer and the register file.
// master: the sequencer's view; slave: the environment (decode/writeback + register file).
interface regfile_port_sequencer_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_rs1;
    logic [ADDR_WIDTH-1:0] req_rs2;
    logic [ADDR_WIDTH-1:0] req_rd;
    logic                  req_we;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rs1_data;
    logic [DATA_WIDTH-1:0] rsp_rs2_data;
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [DATA_WIDTH-1:0] rf_rdata;

    modport master (
        input  req_valid, req_rs1, req_rs2, req_rd, req_we, req_wdata, rsp_ready, rf_rdata,
        output req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, rf_we, rf_addr, rf_wdata
    );

    modport slave (
        output req_valid, req_rs1, req_rs2, req_rd, req_we, req_wdata, rsp_ready, rf_rdata,
        input  req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, rf_we, rf_addr, rf_wdata
    );
endinterface

// File: rtl/regfile_port_sequencer.sv
// Serialises rs1 read, rs2 read and optional rd write onto a single sync-read regfile port.
// Optional macro RF_READ_SKIP_EN: when rs1 == rs2 the second read is skipped (one cycle less).
module regfile_port_sequencer #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    regfile_port_sequencer_if.master        bus,
    output logic                            busy
);
    typedef enum logic [2:0] {IDLE, RD1, RD2, CAP, RESP} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rs1_q, rsp_rs2_q;
    logic                  rf_we_q;
    logic [ADDR_WIDTH-1:0] rf_addr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;

    // Port setup for the CAP cycle: write rd if requested, otherwise keep pointing at rs2.
    logic                  cap_we_d;
    logic [ADDR_WIDTH-1:0] cap_addr_d;
    logic [DATA_WIDTH-1:0] rs1_val_d, rs2_val_d;

    assign cap_we_d   = we_q && (rd_q != '0);
    assign cap_addr_d = cap_we_d ? rd_q : rs2_q;
    assign rs1_val_d  = (rs1_q == '0) ? '0 : bus.rf_rdata;
    assign rs2_val_d  = (rs2_q == '0) ? '0 : bus.rf_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rs1_q   <= '0;
            rsp_rs2_q   <= '0;
            rf_we_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_wdata_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        rs1_q     <= bus.req_rs1;
                        rs2_q     <= bus.req_rs2;
                        rd_q      <= bus.req_rd;
                        we_q      <= bus.req_we;
                        wdata_q   <= bus.req_wdata;
                        rf_we_q   <= 1'b0;
                        rf_addr_q <= bus.req_rs1;
                        state_q   <= RD1;
                    end
                end
                RD1: begin
`ifdef RF_READ_SKIP_EN
                    if (rs1_q == rs2_q) begin
                        rf_we_q    <= cap_we_d;
                        rf_addr_q  <= cap_addr_d;
                        if (cap_we_d) rf_wdata_q <= wdata_q;
                        state_q    <= CAP;
                    end else begin
                        rf_addr_q <= rs2_q;
                        state_q   <= RD2;
                    end
`else
                    rf_addr_q <= rs2_q;
                    state_q   <= RD2;
`endif
                end
                RD2: begin
                    // rf_rdata now reflects the rs1 address driven during RD1
                    rsp_rs1_q  <= rs1_val_d;
                    rf_we_q    <= cap_we_d;
                    rf_addr_q  <= cap_addr_d;
                    if (cap_we_d) rf_wdata_q <= wdata_q;
                    state_q    <= CAP;
                end
                CAP: begin
                    rsp_rs2_q <= rs2_val_d;
`ifdef RF_READ_SKIP_EN
                    if (rs1_q == rs2_q) rsp_rs1_q <= rs1_val_d;
`endif
                    rf_we_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rs1_data = rsp_rs1_q;
    assign bus.rsp_rs2_data = rsp_rs2_q;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_addr      = rf_addr_q;
    assign bus.rf_wdata     = rf_wdata_q;
endmodule

// File: doc/regfile_port_sequencer.md
Name: regfile_port_sequencer

Overview:
- Initiator side of the single-port, synchronous-read register file interface.
- Accepts one RV32I operand/writeback request per transaction (rs1, rs2, optional rd write) over a valid/ready handshake.
- Serialises the accesses onto the single port and returns both operands over a response handshake.
- Sits between decode/writeback control and the register file.

Parameters:
- ADDR_WIDTH, 5: register index width; 32 registers.
- DATA_WIDTH, 32: register data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; request accepted on the edge where req_valid && req_ready.
- req_rs1  input  ADDR_WIDTH  first source index.
- req_rs2  input  ADDR_WIDTH  second source index.
- req_rd  input  ADDR_WIDTH  destination index.
- req_we  input  1  perform a write of req_wdata to req_rd.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  operands available; held until accepted.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rs1_data  output  DATA_WIDTH  value of rs1.
- rsp_rs2_data  output  DATA_WIDTH  value of rs2.
- rf_we  output  1  register file write enable.
- rf_addr  output  ADDR_WIDTH  register file address.
- rf_wdata  output  DATA_WIDTH  register file write data.
- rf_rdata  input  DATA_WIDTH  register file data; registered, reflects the rf_addr driven on the previous cycle.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - rsp_valid=0, rsp_rs1_data=0, rsp_rs2_data=0, rf_we=0, rf_addr=0, rf_wdata=0, busy=0.
  - Request capture registers are cleared.
  - Reset mid-transaction abandons the transaction. No write is issued after reset is released.
- Request capture: on acceptance, rs1, rs2, rd, we and wdata are registered. Inputs are ignored after that until the next acceptance.
- FSM states: IDLE, RD1, RD2, CAP, RESP.
  - IDLE: req_ready=1, rf_we=0. Goes to RD1 on acceptance.
  - RD1: rf_addr=rs1, rf_we=0. Goes to RD2.
  - RD2: rf_addr=rs2, rf_we=0. At the end of the cycle, rsp_rs1_data latches rf_rdata (value of rs1). Goes to CAP.
  - CAP: rsp_rs2_data latches rf_rdata (value of rs2). If we=1 and rd!=0, drive rf_addr=rd, rf_wdata=wdata, rf_we=1; otherwise rf_we=0 and rf_addr=rs2. Goes to RESP.
  - RESP: rsp_valid=1 and data held stable. Goes to IDLE on rsp_ready. req_ready=0, so a new request cannot be accepted in the same cycle as the response handshake.
- Latency: request accepted at edge E0; rsp_valid rises after edge E3; the write commits at edge E3.
- Ordering: reads always precede the write, so rs1/rs2 == rd returns the old value (read-before-write).
- x0 handling:
  - A source index of 0 yields data 0, regardless of rf_rdata.
  - rd=0 never asserts rf_we.
- rf_we is high for at most one cycle per transaction, and only in CAP.

Optional Feature:
- Macro: RF_READ_SKIP_EN.
- Defined: when captured rs1 == rs2, RD1 goes directly to CAP, skipping RD2. CAP latches rf_rdata into both rsp_rs1_data and rsp_rs2_data, and applies the same x0 rule. Latency drops by one: rsp_valid rises after E2.
- Not defined: always RD1 -> RD2 -> CAP, with fixed latency E3.

Test Plan:
- Reset, then preload x5=0x11111111 and x6=0x22222222 via write-only requests (rs1=rs2=0). Request rs1=5, rs2=6, we=0 -> rsp_rs1_data=0x11111111, rsp_rs2_data=0x22222222, rsp_valid after E3, rf_we never high.
- Request rs1=7, rs2=7, rd=7, we=1, wdata=0xDEADBEEF with x7=0xA5A5A5A5 -> both operands 0xA5A5A5A5 (old value); a following read of x7 returns 0xDEADBEEF. With RF_READ_SKIP_EN, rsp_valid rises after E2.
- Request rs1=0, rs2=0, rd=0, we=1, wdata=0xFFFFFFFF, with the model forcing rf_rdata=0x12345678 -> both operands 0, rf_we stays 0 throughout.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0, no rf_we. Then rsp_ready=1 -> IDLE next cycle, req_ready=1.
- Pull rst low while in CAP with we=1, rd=3 -> rf_we falls immediately to 0, outputs zero, IDLE with req_ready=1 after release; x3 unchanged.
- Back-to-back requests with req_valid held high -> exactly one acceptance per transaction, 5 cycles per transaction including IDLE, no overlap of rf accesses.
